// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback scheduler: register index and writeback request payload.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t          rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry FIFO holding LSU writeback requests until they win the register-file write port.
module wb_fifo
    import regfile_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       push,
    input  wb_req_t    push_data,
    input  logic       pop,
    output wb_req_t    head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    wb_req_t mem [2];
    logic    wr_ptr;
    logic    rd_ptr;
    logic    push_ok;
    logic    pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: ALU-priority arbitration, LSU FIFO, busy scoreboard and issue stall.
// Optional feature macro SCOREBOARD_BYPASS_EN: sources being written this cycle do not stall.
module regfile_wb_scheduler #(
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned NREGS     = 32,
    parameter  int unsigned MAX_DEFER = 4,
    localparam int unsigned REG_W     = $clog2(NREGS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              issue_valid,
    input  logic              issue_rd_en,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [REG_W-1:0]  issue_rs1,
    input  logic [REG_W-1:0]  issue_rs2,
    output logic              stall,
    input  logic              alu_wr_valid,
    input  logic [REG_W-1:0]  alu_wr_reg,
    input  logic [DATA_W-1:0] alu_wr_data,
    input  logic              lsu_wr_valid,
    output logic              lsu_wr_ready,
    input  logic [REG_W-1:0]  lsu_wr_reg,
    input  logic [DATA_W-1:0] lsu_wr_data,
    output logic              RegWrite,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] writeData
);

    import regfile_pkg::wb_req_t;
    import regfile_pkg::reg_idx_t;

    localparam int unsigned REQ_DATA_W = $bits(wb_req_t) - $bits(reg_idx_t);
    localparam int unsigned DEF_W      = $clog2(MAX_DEFER + 1);
    localparam logic [NREGS-1:0] X0_MASK = ~NREGS'(1);

    wb_req_t           lsu_req;
    wb_req_t           fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              lsu_push;
    logic              fifo_pop;

    logic              win_valid;
    logic [REG_W-1:0]  win_rd;
    logic [DATA_W-1:0] win_data;
    logic              win_write;

    logic [DEF_W-1:0]  defer_cnt;
    logic              throttle;

    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_set;
    logic [NREGS-1:0]  busy_clr;
    logic              rs1_busy;
    logic              rs2_busy;

    assign lsu_wr_ready = ~fifo_full;
    assign lsu_push     = lsu_wr_valid & lsu_wr_ready;
    assign fifo_pop     = ~alu_wr_valid & ~fifo_empty;

    always_comb begin
        lsu_req      = '0;
        lsu_req.rd   = reg_idx_t'(lsu_wr_reg);
        lsu_req.data = REQ_DATA_W'(lsu_wr_data);
    end

    wb_fifo u_lsu_fifo (
        .CLK       (CLK),
        .RESET     (RESET),
        .push      (lsu_push),
        .push_data (lsu_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ALU never waits; the LSU head takes the port only on ALU-idle cycles.
    always_comb begin
        win_valid = alu_wr_valid | ~fifo_empty;
        win_rd    = alu_wr_reg;
        win_data  = alu_wr_data;
        if (!alu_wr_valid) begin
            win_rd   = REG_W'(fifo_head.rd);
            win_data = DATA_W'(fifo_head.data);
        end
        win_write = win_valid & (win_rd != '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RegWrite  <= 1'b0;
            write_reg <= '0;
            writeData <= '0;
        end else begin
            RegWrite <= win_write;
            if (win_write) begin
                write_reg <= win_rd;
                writeData <= win_data;
            end
        end
    end

    // Counts consecutive cycles the queued LSU result lost to the ALU.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            defer_cnt <= '0;
        end else if (fifo_pop) begin
            defer_cnt <= '0;
        end else if (alu_wr_valid && (fifo_count != 2'd0) && (defer_cnt < DEF_W'(MAX_DEFER))) begin
            defer_cnt <= defer_cnt + DEF_W'(1);
        end
    end

    assign throttle = (defer_cnt >= DEF_W'(MAX_DEFER));

    always_comb begin
        rs1_busy = busy[issue_rs1];
        rs2_busy = busy[issue_rs2];
`ifdef SCOREBOARD_BYPASS_EN
        if (RegWrite && (write_reg == issue_rs1)) begin
            rs1_busy = 1'b0;
        end
        if (RegWrite && (write_reg == issue_rs2)) begin
            rs2_busy = 1'b0;
        end
`endif
        stall = issue_valid &
                (rs1_busy | rs2_busy | (issue_rd_en & busy[issue_rd]) | throttle);
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_valid && issue_rd_en && !stall && (issue_rd != '0)) begin
            busy_set[issue_rd] = 1'b1;
        end
        if (RegWrite) begin
            busy_clr[write_reg] = 1'b1;
        end
    end

    // Set overrides clear; x0 is never tracked.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~busy_clr) | busy_set) & X0_MASK;
        end
    end

endmodule
